// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one outstanding load/store, programmable wait
// states, byte-enabled word storage, alignment/range error reporting.
module data_mem_responder #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  be_reg;
   logic [31:0] rdata_reg;
   logic        err_reg;
   logic        accept;
   logic        access;

   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic          acc_err;
   logic [AW-1:0] acc_idx;
   logic          wr_en;
   logic [3:0]    byte_we;

   logic [31:0] mem [DEPTH_WORDS];

   assign req_ready = (state_reg == IDLE) && !reset;
   assign rsp_valid = (state_reg == RESP);
   assign rsp_rdata = rdata_reg;
   assign rsp_err   = err_reg;
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      access     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_next = RESP;
                  access     = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = RESP;
               access     = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // With zero wait states the access happens at the acceptance edge, so it must
   // use the live request inputs rather than the latched copy.
   always_comb begin
      acc_we    = (state_reg == IDLE) ? req_we    : we_reg;
      acc_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
      acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
      acc_be    = (state_reg == IDLE) ? req_be    : be_reg;
   end

   // Base is word aligned and in-range offsets are below 4*DEPTH_WORDS, so the
   // index can be formed from the word-address bits alone.
   assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr < ADDR_BASE) ||
                    ({1'b0, acc_addr} >= ADDR_END);
   assign acc_idx = acc_addr[AW+1:2] - ADDR_BASE[AW+1:2];
   assign wr_en   = access && acc_we && !acc_err;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
         assign byte_we[gi] = wr_en && acc_be[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         we_reg    <= 1'b0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
         be_reg    <= 4'd0;
         rdata_reg <= 32'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
         end
         if (access) begin
            err_reg   <= acc_err;
            rdata_reg <= (!acc_err && !acc_we) ? mem[acc_idx] : 32'd0;
         end else if ((state_reg == RESP) && rsp_ready) begin
            err_reg   <= 1'b0;
            rdata_reg <= 32'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < DEPTH_WORDS; w++) mem[w] <= 32'd0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (byte_we[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

endmodule
